prio_arbiter_rr_hold: RTL and testbench
=======================================

// Module: prio_arbiter_rr_hold
// PURPOSE
//  Registered, parametrised SIZE-way arbiter with grant lock. Fixed MSB-to-LSB
//  priority or MSB-to-LSB round-robin, selected at elaboration. A grant is held
//  while the owner keeps req high, optionally capped by MAX_HOLD to force rotation.
//  Sits in front of shared resources such as buses and memory ports, where a
//  transaction spans multiple cycles.
// PARAMETERS
//  SIZE      4  number of requesters (>=2)
//  RR_EN     1  0: fixed priority, highest index wins; 1: round-robin rotating MSB->LSB
//  MAX_HOLD  0  max consecutive grant cycles before forced re-arbitration; 0 = unlimited
// PORTS
//  clk      input   1                  clock, rising edge
//  rst      input   1                  reset, asynchronous, active-high
//  req      input   SIZE               request per requester; held high for whole transaction
//  gnt      output  SIZE               registered one-hot grant; all-zero when idle
//  gnt_vld  output  1                  |gnt
//  gnt_idx  output  $clog2(SIZE)       binary index of owner; 0 when idle
// BEHAVIOUR
//  Reset (async assert, takes effect without a clock edge):
//   - Outputs: gnt=0, gnt_vld=0, gnt_idx=0.
//   - Internal state: ptr=0, hold_cnt=0, state=IDLE.
//   - Deassertion is synchronous to clk externally.
//  Reset mid-grant: gnt drops immediately; arbitration restarts from ptr=0.
//  All decisions are made on the rising edge of clk using the req value present at that edge.
//  State IDLE (gnt=0):
//   - If |req: load the winner next cycle. Latency req->gnt is 1 cycle. Go to GRANT.
//   - Otherwise stay in IDLE.
//  State GRANT (owner o, gnt=1<<o):
//   - req[o]=1, no cap hit: hold gnt; hold_cnt++ (saturating).
//   - req[o]=0, other req pending: switch straight to the new winner, with no idle bubble.
//   - req[o]=0, no other req: return to IDLE.
//   - Cap hit (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[o]=1):
//     - Other req pending: grant the winner among req & ~(1<<o).
//     - None pending: keep o and clear hold_cnt.
//  Winner selection:
//   - RR_EN=0: highest set index of the candidate mask.
//   - RR_EN=1: scan ptr-1, ptr-2, ... wrapping SIZE-1 -> 0; first set bit wins.
//     The owner is scanned last. ptr=0 at reset, so the first scan starts at SIZE-1.
//  ptr and hold_cnt on every new grant (including re-grant of the same index from IDLE):
//   - ptr <= winner index.
//   - hold_cnt <= 0.
//  hold_cnt width: $clog2(MAX_HOLD+1), minimum 1. Unused when MAX_HOLD=0.
//  gnt is one-hot or zero at all times. gnt_idx and gnt_vld are registered with gnt,
//  so all three are consistent in the same cycle.
//  Only a requester whose req bit is 1 at the decision edge can receive a grant.
// TESTING (SIZE=4)
//  1 rst=1 with req=1111 -> gnt=0000. Release -> first edge gives gnt=1000, idx=3, vld=1.
//  2 RR_EN=0, req=0101 -> gnt=0100 held. Then req=0001 -> next edge gnt=0001, no IDLE cycle.
//  3 RR_EN=1, req=1111; each owner drops req for 1 cycle after its grant, then re-raises
//    -> grant order 1000,0100,0010,0001,1000.
//  4 RR_EN=1, MAX_HOLD=3, req=1001 constant -> 1000 for 3 cycles, 0001 for 3, 1000 for 3.
//  5 MAX_HOLD=3, req=1000 only -> gnt=1000 held indefinitely; hold_cnt wraps to 0 each cap.
//  6 Assert rst between edges while gnt=0010 -> gnt=0000 at once. Release with req=0011
//    -> gnt=0010 (scan from ptr=0 starts at index 3).
//  Every cycle: assert $onehot0(gnt), gnt_vld==|gnt, (gnt & ~req_at_decision_edge)==0.

Source files
------------

// File: rtl/prio_arbiter_rr_hold.sv
// Registered SIZE-way arbiter with grant lock: fixed or round-robin priority,
// with an optional cap on consecutive grant cycles that forces rotation.
module prio_arbiter_rr_hold #(
    parameter int SIZE     = 4,
    parameter int RR_EN    = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIZE-1:0]         req,
    output logic [SIZE-1:0]         gnt,
    output logic                    gnt_vld,
    output logic [$clog2(SIZE)-1:0] gnt_idx
);

    // state | meaning
    // IDLE  | no owner, gnt=0, waiting for any request
    // GRANT | owner r_gnt_idx holds the resource while its req stays high
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam int IW  = $clog2(SIZE);
    localparam int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] CAP_VAL = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] CNT_MAX = '1;

    state_t            r_state;
    state_t            w_nstate;
    logic [SIZE-1:0]   r_gnt;
    logic              r_gnt_vld;
    logic [IW-1:0]     r_gnt_idx;
    logic [IW-1:0]     r_ptr;
    logic [HCW-1:0]    r_hold_cnt;

    logic [SIZE-1:0]   w_win_mask;
    logic [IW-1:0]     w_win_idx;
    logic [SIZE-1:0]   w_others;
    logic              w_own_req;
    logic              w_cap;
    logic              w_load;
    logic              w_go_idle;
    logic              w_cnt_clear;
    logic              w_cnt_inc;

    // Round-robin scans downward from ptr-1 and wraps, so the last owner is visited last.
    function automatic logic [IW-1:0] pick(input logic [SIZE-1:0] mask,
                                           input logic [IW-1:0]   ptr);
        logic [IW-1:0] idx;
        logic          found;
        int            j;
        idx   = '0;
        found = 1'b0;
        if (RR_EN != 0) begin
            for (int k = 1; k <= SIZE; k++) begin
                j = (int'(ptr) + SIZE - k) % SIZE;
                if (!found && mask[j]) begin
                    idx   = IW'(j);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                if (mask[i]) begin
                    idx = IW'(i);
                end
            end
        end
        return idx;
    endfunction

    assign w_own_req = req[r_gnt_idx];
    assign w_others  = req & ~r_gnt;
    assign w_cap     = (MAX_HOLD != 0) && (r_hold_cnt == CAP_VAL);

    always_comb begin
        w_nstate    = r_state;
        w_win_mask  = req;
        w_load      = 1'b0;
        w_go_idle   = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_load   = 1'b1;
                    w_nstate = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_own_req) begin
                    if (|req) begin
                        w_load = 1'b1;
                    end else begin
                        w_go_idle = 1'b1;
                        w_nstate  = S_IDLE;
                    end
                end else if (w_cap) begin
                    // Cap reached: rotate only if someone else is waiting.
                    if (|w_others) begin
                        w_load     = 1'b1;
                        w_win_mask = w_others;
                    end else begin
                        w_cnt_clear = 1'b1;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
        w_win_idx = pick(w_win_mask, r_ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_nstate;
            if (w_load) begin
                r_gnt      <= SIZE'(1) << w_win_idx;
                r_gnt_vld  <= 1'b1;
                r_gnt_idx  <= w_win_idx;
                r_ptr      <= w_win_idx;
                r_hold_cnt <= '0;
            end else if (w_go_idle) begin
                r_gnt     <= '0;
                r_gnt_vld <= 1'b0;
                r_gnt_idx <= '0;
            end else if (w_cnt_clear) begin
                r_hold_cnt <= '0;
            end else if (w_cnt_inc && (r_hold_cnt != CNT_MAX)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gnt_vld;
    assign gnt_idx = r_gnt_idx;

endmodule

// File: tb/tb_prio_arbiter_rr_hold.sv
// Bench for prio_arbiter_rr_hold: four configurations share one req/rst stream
// and are compared each cycle against an integer-level reference model.
module tb_prio_arbiter_rr_hold;

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [3:0][3:0] gnt_o;
    logic [3:0][1:0] idx_o;
    logic [3:0]      vld_o;

    int checks = 0;
    int errors = 0;

    // instance: 0 fixed/no cap, 1 rr/no cap, 2 rr/cap 3, 3 fixed/cap 2
    int rr_cfg [4] = '{0, 1, 1, 0};
    int mh_cfg [4] = '{0, 0, 3, 2};

    typedef struct {
        int owner;
        int ptr;
        int cnt;
    } mst_t;

    mst_t m [4];

    prio_arbiter_rr_hold #(.SIZE(4), .RR_EN(0), .MAX_HOLD(0)) u_fp (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[0]), .gnt_vld(vld_o[0]), .gnt_idx(idx_o[0]));
    prio_arbiter_rr_hold #(.SIZE(4), .RR_EN(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[1]), .gnt_vld(vld_o[1]), .gnt_idx(idx_o[1]));
    prio_arbiter_rr_hold #(.SIZE(4), .RR_EN(1), .MAX_HOLD(3)) u_rc (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[2]), .gnt_vld(vld_o[2]), .gnt_idx(idx_o[2]));
    prio_arbiter_rr_hold #(.SIZE(4), .RR_EN(0), .MAX_HOLD(2)) u_fc (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[3]), .gnt_vld(vld_o[3]), .gnt_idx(idx_o[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int m_pick(logic [3:0] mask, int rr, int ptr);
        int w = -1;
        if (rr == 0) begin
            for (int i = 3; i >= 0; i--) if (mask[i] && w < 0) w = i;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int j = (ptr - k + 4) % 4;
                if (mask[j] && w < 0) w = j;
            end
        end
        return w;
    endfunction

    function automatic mst_t m_grant(mst_t s, int w);
        mst_t n = s;
        n.owner = w;
        n.ptr   = w;
        n.cnt   = 0;
        return n;
    endfunction

    function automatic mst_t m_step(mst_t s, logic [3:0] r, int rr, int mh);
        mst_t       n = s;
        logic [3:0] others;
        if (s.owner < 0) begin
            if (r != 4'b0) n = m_grant(s, m_pick(r, rr, s.ptr));
        end else if (!r[s.owner]) begin
            if (r != 4'b0) n = m_grant(s, m_pick(r, rr, s.ptr));
            else n.owner = -1;
        end else if (mh != 0 && s.cnt == mh - 1) begin
            others = r & ~(4'b0001 << s.owner);
            if (others != 4'b0) n = m_grant(s, m_pick(others, rr, s.ptr));
            else n.cnt = 0;
        end else begin
            n.cnt = (s.cnt < 1000) ? s.cnt + 1 : s.cnt;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic [3:0] r);
        logic [3:0] eg;
        logic [1:0] ei;
        for (int i = 0; i < 4; i++) begin
            eg = (m[i].owner < 0) ? 4'b0000 : (4'b0001 << m[i].owner);
            ei = (m[i].owner < 0) ? 2'd0 : 2'(m[i].owner);
            chk($sformatf("gnt[%0d]", i), gnt_o[i], eg);
            chk($sformatf("idx[%0d]", i), {2'b00, idx_o[i]}, {2'b00, ei});
            chk($sformatf("vld[%0d]", i), {3'b000, vld_o[i]}, {3'b000, (m[i].owner >= 0)});
            chk($sformatf("onehot0[%0d]", i), {3'b000, $onehot0(gnt_o[i])}, 4'b0001);
            chk($sformatf("vld_or[%0d]", i), {3'b000, vld_o[i]}, {3'b000, |gnt_o[i]});
            chk($sformatf("gnt_req[%0d]", i), gnt_o[i] & ~r, 4'b0000);
        end
    endtask

    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        for (int i = 0; i < 4; i++) m[i] = m_step(m[i], r, rr_cfg[i], mh_cfg[i]);
        #1;
        check_all(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m[i].owner = -1;
            m[i].ptr   = 0;
            m[i].cnt   = 0;
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_gnt[%0d]", i), gnt_o[i], 4'b0000);
            chk($sformatf("rst_vld[%0d]", i), {3'b000, vld_o[i]}, 4'b0000);
            chk($sformatf("rst_idx[%0d]", i), {2'b00, idx_o[i]}, 4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] t3_req [5] = '{4'b1111, 4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] t3_exp [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [3:0] t4_exp [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001,
                              4'b0001, 4'b1000, 4'b1000, 4'b1000};

    initial begin
        logic [3:0] rq;
        rst = 1'b1;
        req = 4'b1111;
        model_reset();
        #7;
        for (int i = 0; i < 4; i++) chk($sformatf("t1_rst_gnt[%0d]", i), gnt_o[i], 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b1111);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_gnt[%0d]", i), gnt_o[i], 4'b1000);
            chk($sformatf("t1_idx[%0d]", i), {2'b00, idx_o[i]}, 4'd3);
        end

        cycle(4'b0101);
        chk("t2_fp_a", gnt_o[0], 4'b0100);
        cycle(4'b0101);
        chk("t2_fp_hold", gnt_o[0], 4'b0100);
        cycle(4'b0001);
        chk("t2_fp_switch", gnt_o[0], 4'b0001);

        do_reset();
        for (int s = 0; s < 5; s++) begin
            cycle(t3_req[s]);
            chk($sformatf("t3_rr_step%0d", s), gnt_o[1], t3_exp[s]);
        end

        do_reset();
        for (int s = 0; s < 9; s++) begin
            cycle(4'b1001);
            chk($sformatf("t4_cap_step%0d", s), gnt_o[2], t4_exp[s]);
        end

        do_reset();
        for (int s = 0; s < 8; s++) begin
            cycle(4'b1000);
            chk($sformatf("t5_solo_step%0d", s), gnt_o[2], 4'b1000);
        end

        do_reset();
        cycle(4'b0010);
        chk("t6_pre", gnt_o[1], 4'b0010);
        do_reset();
        cycle(4'b0011);
        chk("t6_post", gnt_o[1], 4'b0010);

        rq = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) rq[b] = ~rq[b];
            cycle(rq);
            if ($urandom_range(59) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
